// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, byte held in rx_data until acked.
// Latency: rx_valid rises about 9.5 bit times plus 3 cycles after the start edge; no backpressure, a byte arriving while unacked is dropped and flagged as overrun.
module uart_rx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       framing_error,
  output logic       overrun,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int TW           = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_LAST = TW'(HALF_BIT - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t        state, state_nxt;
  logic          rx_meta, rx_s;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          sample;
  logic          stop_good, stop_bad, load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sample    = 1'b0;
    case (state)
      IDLE:      if (!rx_s) state_nxt = START;
      START: begin
        if (timer == HALF_LAST) begin
          sample    = 1'b1;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer == BIT_LAST) begin
          sample = 1'b1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (timer == BIT_LAST) begin
          sample    = 1'b1;
          state_nxt = rx_s ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: if (rx_s) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    stop_good = (state == STOP) && sample && rx_s;
    stop_bad  = (state == STOP) && sample && !rx_s;
    load      = stop_good && (!rx_valid || rx_ack);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer         <= '0;
      bit_idx       <= '0;
      shift_reg     <= '0;
      rx_data       <= 8'h00;
      rx_valid      <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      framing_error <= stop_bad;
      overrun       <= stop_good && !load;

      // Timer restarts at every bit boundary and state change; it idles at zero outside timed states.
      if (state_nxt != state || sample)
        timer <= '0;
      else if (state == START || state == DATA || state == STOP)
        timer <= timer + 1'b1;

      if (state == START)
        bit_idx <= '0;
      else if (state == DATA && sample) begin
        shift_reg[bit_idx] <= rx_s;
        bit_idx            <= bit_idx + 3'd1;
      end

      if (load) begin
        rx_data  <= shift_reg;
        rx_valid <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: drives 8N1 frames on rx and compares against a frame-level holding-register model.
module tb_uart_rx;

  localparam int CPB  = 434;
  localparam int HALF = 217;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       framing_error;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int busy_run = 0;
  int busy_max = 0;

  // Frame-level model of the holding register and error counters
  bit         m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  int         m_fe = 0;
  int         m_ov = 0;

  always #5 clk = ~clk;

  uart_rx dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ack(rx_ack),
    .framing_error(framing_error),
    .overrun(overrun),
    .busy(busy)
  );

  always @(negedge clk) begin
    if (framing_error === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ov_cnt++;
    if (busy === 1'b1) busy_run++;
    else busy_run = 0;
    if (busy_run > busy_max) busy_max = busy_run;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic model_frame(input logic [7:0] d, input logic stop_bit);
    if (!stop_bit) m_fe++;
    else if (!m_valid) begin
      m_data  = d;
      m_valid = 1'b1;
    end else m_ov++;
  endtask

  task automatic do_ack();
    @(negedge clk) rx_ack = 1'b1;
    @(negedge clk) rx_ack = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rx_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rx_data"}, 32'(rx_data), 32'(m_data));
    check({tag, ".rx_valid"}, 32'(rx_valid), 32'(m_valid));
    check({tag, ".framing_errors"}, fe_cnt, m_fe);
    check({tag, ".overruns"}, ov_cnt, m_ov);
  endtask

  initial begin
    bit ok;
    logic [7:0] b;

    #2;
    check("reset.rx_data", 32'(rx_data), 0);
    check("reset.rx_valid", 32'(rx_valid), 0);
    check("reset.busy", 32'(busy), 0);
    check("reset.framing_error", 32'(framing_error), 0);
    check("reset.overrun", 32'(overrun), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single byte, no ack: must be valid within one frame time of the start edge
    send_frame(8'hA5, 1'b1);
    model_frame(8'hA5, 1'b1);
    check_all("a5");
    do_ack();
    check("a5_ack.rx_valid", 32'(rx_valid), 0);

    // Back-to-back frames with ack one cycle after the first byte shows up
    fork
      begin
        send_frame(8'h3C, 1'b1);
        send_frame(8'h81, 1'b1);
      end
      begin
        wait_valid(11 * CPB, ok);
        check("b2b.first_valid_seen", 32'(ok), 1);
        check("b2b.first_data", 32'(rx_data), 32'h3C);
        @(negedge clk) rx_ack = 1'b1;
        @(negedge clk) rx_ack = 1'b0;
        check("b2b.valid_gap", 32'(rx_valid), 0);
        wait_valid(11 * CPB, ok);
        check("b2b.second_valid_seen", 32'(ok), 1);
        check("b2b.second_data", 32'(rx_data), 32'h81);
      end
    join
    model_frame(8'h3C, 1'b1);
    m_valid = 1'b0;
    model_frame(8'h81, 1'b1);
    check_all("b2b");
    do_ack();

    // Bad stop bit, then a good frame
    send_frame(8'h55, 1'b0);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    model_frame(8'h55, 1'b0);
    check_all("stop_low");
    send_frame(8'h0F, 1'b1);
    model_frame(8'h0F, 1'b1);
    check_all("after_fe");
    do_ack();

    // Break: twenty bit times low yields one framing error only
    rx = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    m_fe++;
    check_all("break");
    check("break.busy_released", 32'(busy), 0);

    // Short glitch: false start, brief busy, nothing else
    busy_max = 0;
    rx = 1'b0;
    repeat (100) @(negedge clk);
    rx = 1'b1;
    repeat (HALF + 20) @(negedge clk);
    check("glitch.busy_seen", 32'(busy_max > 0), 1);
    check("glitch.busy_bounded", 32'(busy_max <= HALF + 2), 1);
    check("glitch.busy_now", 32'(busy), 0);
    check_all("glitch");

    // Overrun: second byte lands while the first is still unacked
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    model_frame(8'h11, 1'b1);
    model_frame(8'h22, 1'b1);
    check_all("overrun");

    // Asynchronous reset in the middle of a third frame
    fork
      send_frame(8'h5A, 1'b1);
      begin
        repeat (5 * CPB) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midreset.rx_data", 32'(rx_data), 0);
        check("midreset.rx_valid", 32'(rx_valid), 0);
        check("midreset.busy", 32'(busy), 0);
        check("midreset.framing_error", 32'(framing_error), 0);
        check("midreset.overrun", 32'(overrun), 0);
      end
    join
    @(negedge clk) rst = 1'b0;
    m_valid = 1'b0;
    m_data  = 8'h00;
    repeat (CPB) @(negedge clk);
    check_all("post_reset");

    // Random bytes with random acks, overruns predicted by the model
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1);
      model_frame(b, 1'b1);
      check_all($sformatf("rand%0d", i));
      if ($urandom_range(0, 1) == 1) do_ack();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver for the core's serial input; the receive-side counterpart of the core's UART transmitter on the Tx/Rx pin pair.
- Synchronises the asynchronous Rx pin and samples 8N1 frames, LSB first, at mid-bit.
- Presents each received byte in a holding register with a valid/ack handshake, and reports framing and overrun errors.

Parameters:
- CLK_FREQ, 50000000, clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- CLKS_PER_BIT (localparam), CLK_FREQ/BAUD with integer floor (434 at defaults); HALF_BIT = CLKS_PER_BIT/2 (217).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  serial input pin; asynchronous to clk; idle high.
- rx_data  out  8  last accepted byte.
- rx_valid  out  1  high while rx_data holds an unconsumed byte.
- rx_ack  in  1  consumer strobe; clears rx_valid.
- framing_error  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: a byte completed while rx_valid was high and rx_ack was low.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst=1):
  - Both synchroniser FFs = 1.
  - State = IDLE, counters = 0.
  - rx_data = 8'h00; rx_valid, framing_error, overrun, busy = 0.
- Synchroniser:
  - Two flops; rx_s is the second flop.
  - All decisions use rx_s only, giving 2 cycles of pin-to-logic latency.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: rx_s==0 → START, bit-timer = 0.
- START:
  - When timer reaches HALF_BIT-1, sample rx_s.
  - rx_s==1: false start, return to IDLE with no outputs.
  - rx_s==0: go to DATA with bit index = 0 and timer reset.
- DATA:
  - Every CLKS_PER_BIT cycles, shift rx_s into the shift register at position bit index (LSB first).
  - After index 7 → STOP.
- STOP: after CLKS_PER_BIT cycles, sample rx_s.
  - rx_s==1 (good frame):
    - rx_valid==0, or rx_ack==1 in the same cycle: load rx_data from the shift register; rx_valid = 1 on the next edge.
    - Otherwise: keep the old rx_data, pulse overrun for 1 cycle, discard the new byte.
    - Go to IDLE.
  - rx_s==0 (bad frame): pulse framing_error; rx_data and rx_valid unchanged; go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then go to IDLE. A break (continuous low) therefore produces exactly one framing_error and never retriggers.
- Sample points, measured from the first cycle rx_s==0: start at HALF_BIT; data bit k at HALF_BIT + (k+1)·CLKS_PER_BIT; stop at HALF_BIT + 9·CLKS_PER_BIT.
- Back-to-back frames: returning to IDLE at mid-stop-bit lets the next start edge be detected without a gap.
- Handshake:
  - rx_ack while rx_valid==1 clears rx_valid on the next edge.
  - rx_ack while rx_valid==0 has no effect.
  - rx_ack coinciding with a good-frame load: new byte is loaded, rx_valid stays 1, no overrun.
- busy = (state != IDLE), registered with the state.
- Reset mid-frame: all state is cleared immediately; the partial byte is lost.
  - After release, if rx is still low, the block enters START on that low. A frame already in progress may then be misread; this is accepted.
- Timer width: ceil(log2(CLKS_PER_BIT)) bits. The timer resets on every state transition and never wraps inside a bit.

Test Plan (defaults: 434 clk/bit, 8.68 µs/bit):
- Send 0xA5 (8N1, line idle high), no ack → rx_data=8'hA5, rx_valid=1 within 10·434+4 cycles of the start edge; framing_error=0, overrun=0.
- Send 0x3C then 0x81 back-to-back, rx_ack pulsed 1 cycle after the first rx_valid → rx_data=0x3C, then 0x81; rx_valid drops for ≥1 cycle between the two bytes; no errors.
- Send 0x55 with the stop bit driven low, then idle high → one framing_error pulse; rx_valid stays 0; the next 0x0F frame is received correctly.
- Hold rx low for 20 bit times, then high → exactly one framing_error pulse; no rx_valid; busy returns to 0 after rx goes high.
- Low glitch of 100 cycles on rx → false start; busy high for ≤HALF_BIT+2 cycles, then 0; no outputs change.
- Receive 0x11 without ack, then 0x22 → overrun pulses once, rx_data remains 0x11; assert rst at the mid-point of a third frame → all outputs 0 asynchronously.
